// File: rtl/frame_scanout_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_scanout_reader_pkg                                        |
// | Purpose  : Video timing / frame buffer constants shared by the frame       |
// |            renderer and scanout reader, fetch FSM state type and the line  |
// |            base address helper.                                            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package frame_scanout_reader_pkg;

  localparam int H_ACTIVE      = 640;     // visible pixels per line
  localparam int V_ACTIVE      = 480;     // visible lines per frame
  localparam int V_TOTAL       = 525;     // total lines per frame incl. blanking
  localparam int BUFFER_OFFSET = 307200;  // SRAM word offset of buffer 1
  localparam int IDX_W         = 5;       // palette index width
  localparam int ADDR_W        = 20;      // SRAM word address width
  localparam int DATA_W        = 16;      // SRAM data width
  localparam int COORD_W       = 10;      // DrawX / DrawY width
  localparam int COL_W         = 10;      // line buffer column index width
  localparam int LINE_W        = 9;       // active line number width (0..479)

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Word offset of an active line inside a buffer: line*640 built from two
  // shifts (512 + 128) so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] line_offset(input logic [LINE_W-1:0] line);
    logic [ADDR_W-1:0] l_ext;
    l_ext       = {{(ADDR_W-LINE_W){1'b0}}, line};
    line_offset = (l_ext << 9) + (l_ext << 7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scanout_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scanout_line_buffer                                             |
// | Purpose  : Ping-pong line store, 2 banks x H_ACTIVE entries x IDX_W bits.  |
// |            One write port (SRAM side), one registered read port (beam).    |
// | Ports    : Clk        - system clock                                       |
// |            i_wr_en    - write strobe                                       |
// |            i_wr_bank  - bank written                                       |
// |            i_wr_col   - column written                                     |
// |            i_wr_data  - palette index written                              |
// |            i_rd_bank  - bank read                                          |
// |            i_rd_col   - column read                                        |
// |            o_rd_data  - read data, one cycle after address                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module scanout_line_buffer
  import frame_scanout_reader_pkg::*;
(
  input  logic             Clk,
  input  logic             i_wr_en,
  input  logic             i_wr_bank,
  input  logic [COL_W-1:0] i_wr_col,
  input  logic [IDX_W-1:0] i_wr_data,
  input  logic             i_rd_bank,
  input  logic [COL_W-1:0] i_rd_col,
  output logic [IDX_W-1:0] o_rd_data
);

  logic [IDX_W-1:0] r_mem [0:1][0:H_ACTIVE-1];

  // Contents are deliberately not reset; the top gates the output outside
  // the active area. A same-cycle read of a written entry returns old data.
  always_ff @(posedge Clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_col] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_bank][i_rd_col];
  end

endmodule
`default_nettype wire

// File: rtl/frame_scanout_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_scanout_reader                                            |
// | Purpose  : Fetches the front frame buffer from SRAM one line ahead of the  |
// |            VGA beam into a ping-pong line buffer and streams palette       |
// |            indices; pulses draw_frame at the start of vertical blank.      |
// | Ports    : Clk           - system clock (>= 2x pixel clock)                |
// |            Reset         - synchronous, active-high                        |
// |            buffer_select - renderer back buffer; reader shows the other    |
// |            DrawX/DrawY   - beam position                                   |
// |            sram_rd_req   - read request, held until sram_rd_ack            |
// |            sram_rd_addr  - read word address, stable while requesting      |
// |            sram_rd_ack   - one-cycle grant, data valid same cycle          |
// |            sram_rd_data  - read data                                       |
// |            pixel_index   - palette index, 1-cycle latency, 0 when blanked  |
// |            draw_frame    - pulse when vertical blank begins                |
// |            underrun      - pulse when a line fetch was not finished in time|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module frame_scanout_reader
  import frame_scanout_reader_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               buffer_select,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               sram_rd_req,
  output logic [ADDR_W-1:0]  sram_rd_addr,
  input  logic               sram_rd_ack,
  input  logic [DATA_W-1:0]  sram_rd_data,
  output logic [IDX_W-1:0]   pixel_index,
  output logic               draw_frame,
  output logic               underrun
);

  fetch_state_t             r_state;
  fetch_state_t             w_state_nxt;
  logic [COORD_W-1:0]       r_drawy_q;
  logic [COL_W-1:0]         r_col;
  logic [COL_W-1:0]         w_col_nxt;
  logic [LINE_W-1:0]        r_tgt;
  logic [LINE_W-1:0]        w_tgt_nxt;
  logic                     r_bank;
  logic                     w_bank_nxt;
  logic [ADDR_W-1:0]        r_front_base;
  logic                     r_draw_frame;
  logic                     r_underrun;
  logic                     w_underrun_nxt;
  logic                     r_active;

  logic                     w_event;
  logic [COORD_W-1:0]       w_target;
  logic                     w_target_active;
  logic                     w_last_col;
  logic                     w_wr_en;
  logic [COL_W-1:0]         w_rd_col;
  logic [IDX_W-1:0]         w_rd_data;
  logic [DATA_W-IDX_W-1:0]  w_unused_data_hi;

  // Only the palette index bits of the SRAM word are stored.
  assign w_unused_data_hi = sram_rd_data[DATA_W-1:IDX_W];

  // A line event is any change of DrawY; the line to prefetch is the next
  // one, wrapping the last blanking line onto line 0.
  assign w_event         = (DrawY != r_drawy_q);
  assign w_target        = (DrawY == COORD_W'(V_TOTAL-1)) ? '0 : DrawY + COORD_W'(1);
  assign w_target_active = (w_target < COORD_W'(V_ACTIVE));
  assign w_last_col      = (r_col == COL_W'(H_ACTIVE-1));
  assign w_wr_en         = (r_state == FETCH) && sram_rd_ack && !Reset;

  // Next-state logic. An ack is always applied to the fetch in flight first,
  // so a grant coinciding with a line event still lands in the old line.
  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_tgt_nxt      = r_tgt;
    w_bank_nxt     = r_bank;
    w_underrun_nxt = 1'b0;

    if ((r_state == FETCH) && sram_rd_ack) begin
      if (w_last_col) begin
        w_state_nxt = IDLE;
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end
    end

    if (w_event) begin
      // Still fetching when the beam reaches the next line: flag it and
      // drop the stale fetch, unless this very ack was its final word.
      if ((r_state == FETCH) && !(sram_rd_ack && w_last_col)) begin
        w_underrun_nxt = 1'b1;
      end
      if (w_target_active) begin
        w_state_nxt = FETCH;
        w_col_nxt   = '0;
        w_tgt_nxt   = w_target[LINE_W-1:0];
        w_bank_nxt  = w_target[0];
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    // Tracking DrawY through reset keeps the first cycle after release from
    // seeing a spurious line event.
    r_drawy_q <= DrawY;
    if (Reset) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_tgt        <= '0;
      r_bank       <= 1'b0;
      r_front_base <= '0;
      r_draw_frame <= 1'b0;
      r_underrun   <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_tgt      <= w_tgt_nxt;
      r_bank     <= w_bank_nxt;
      r_underrun <= w_underrun_nxt;
      // Front buffer is latched once per frame, when line 0 is targeted; a
      // fetch starting on the same event sees the new base next cycle.
      if (w_event && (w_target == '0)) begin
        r_front_base <= buffer_select ? '0 : ADDR_W'(BUFFER_OFFSET);
      end
      r_draw_frame <= w_event && (DrawY == COORD_W'(V_ACTIVE));
      r_active     <= (DrawX < COORD_W'(H_ACTIVE)) && (DrawY < COORD_W'(V_ACTIVE));
    end
  end

  assign sram_rd_req  = (r_state == FETCH);
  assign sram_rd_addr = r_front_base + line_offset(r_tgt) + ADDR_W'(r_col);

  // Off-screen columns are clamped to keep the read in range; the result is
  // discarded by the active-area gate anyway.
  assign w_rd_col = (DrawX < COORD_W'(H_ACTIVE)) ? DrawX : '0;

  scanout_line_buffer u_line_buffer (
    .Clk       (Clk),
    .i_wr_en   (w_wr_en),
    .i_wr_bank (r_bank),
    .i_wr_col  (r_col),
    .i_wr_data (sram_rd_data[IDX_W-1:0]),
    .i_rd_bank (DrawY[0]),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data)
  );

  assign pixel_index = r_active ? w_rd_data : '0;
  assign draw_frame  = r_draw_frame;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire
